// File: rtl/acc_fpu_dispatch_if.sv
// -----------------------------------------------------------------------------
// acc_fpu_dispatch_if
// Bundles the instruction, FPU request/response, writeback and status signals
// of the accelerator-to-FPU dispatcher. Signal suffixes are from the
// dispatcher's point of view.
//   slave  : dispatcher side (acc_fpu_dispatch)
//   master : environment side (front-end, FPU, register file)
// -----------------------------------------------------------------------------
interface acc_fpu_dispatch_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_TAGS       = 4
);
    localparam int TAG_WIDTH = $clog2(NUM_TAGS);

    // Instruction front-end
    logic                        instr_valid_i;
    logic                        instr_ready_o;
    logic [3:0]                  instr_op_i;
    logic                        instr_op_mod_i;
    logic [3*DATA_WIDTH-1:0]     instr_operands_i;
    logic [REG_ADDR_WIDTH-1:0]   instr_rd_i;

    // FPU request
    logic                        fpu_req_valid_o;
    logic                        fpu_req_ready_i;
    logic [3:0]                  fpu_req_op_o;
    logic                        fpu_req_op_mod_o;
    logic [3*DATA_WIDTH-1:0]     fpu_req_operands_o;
    logic [TAG_WIDTH-1:0]        fpu_req_tag_o;

    // FPU response
    logic                        fpu_resp_valid_i;
    logic                        fpu_resp_ready_o;
    logic [DATA_WIDTH-1:0]       fpu_resp_result_i;
    logic [4:0]                  fpu_resp_status_i;
    logic [TAG_WIDTH-1:0]        fpu_resp_tag_i;

    // In-order writeback
    logic                        wb_valid_o;
    logic                        wb_ready_i;
    logic [REG_ADDR_WIDTH-1:0]   wb_rd_o;
    logic [DATA_WIDTH-1:0]       wb_data_o;

    // Status / observability
    logic [4:0]                  status_acc_o;
    logic                        clr_status_i;
    logic [TAG_WIDTH:0]          outstanding_o;
    logic                        tag_err_o;

    modport slave (
        input  instr_valid_i, instr_op_i, instr_op_mod_i, instr_operands_i, instr_rd_i,
        output instr_ready_o,
        output fpu_req_valid_o, fpu_req_op_o, fpu_req_op_mod_o, fpu_req_operands_o, fpu_req_tag_o,
        input  fpu_req_ready_i,
        input  fpu_resp_valid_i, fpu_resp_result_i, fpu_resp_status_i, fpu_resp_tag_i,
        output fpu_resp_ready_o,
        output wb_valid_o, wb_rd_o, wb_data_o,
        input  wb_ready_i,
        output status_acc_o, outstanding_o, tag_err_o,
        input  clr_status_i
    );

    modport master (
        output instr_valid_i, instr_op_i, instr_op_mod_i, instr_operands_i, instr_rd_i,
        input  instr_ready_o,
        input  fpu_req_valid_o, fpu_req_op_o, fpu_req_op_mod_o, fpu_req_operands_o, fpu_req_tag_o,
        output fpu_req_ready_i,
        output fpu_resp_valid_i, fpu_resp_result_i, fpu_resp_status_i, fpu_resp_tag_i,
        input  fpu_resp_ready_o,
        input  wb_valid_o, wb_rd_o, wb_data_o,
        output wb_ready_i,
        input  status_acc_o, outstanding_o, tag_err_o,
        output clr_status_i
    );
endinterface

// File: rtl/acc_fpu_dispatch.sv
// -----------------------------------------------------------------------------
// acc_fpu_dispatch
// Tagged dispatcher between the accelerator front-end and the FPU. Accepted
// instructions are allocated a reorder-buffer entry whose index is used as the
// FPU tag; responses may return out of order and are retired in program order
// to the register-file write port. Retired status flags are accumulated.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : acc_fpu_dispatch_if.slave (instruction in, FPU request out,
//             FPU response in, writeback out, status/outstanding/tag_err out)
// -----------------------------------------------------------------------------
module acc_fpu_dispatch #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_TAGS       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    acc_fpu_dispatch_if.slave    bus
);
    localparam int TAG_WIDTH = $clog2(NUM_TAGS);
    localparam logic [TAG_WIDTH:0] PTR_ONE = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH:0] PTR_FULL = (TAG_WIDTH+1)'(NUM_TAGS);

    typedef enum logic [1:0] {
        E_FREE   = 2'd0,
        E_ISSUED = 2'd1,
        E_DONE   = 2'd2
    } entry_state_e;

    // ROB control state
    entry_state_e              state_q [NUM_TAGS];
    entry_state_e              state_d [NUM_TAGS];
    logic [TAG_WIDTH:0]        head_q, head_d;
    logic [TAG_WIDTH:0]        tail_q, tail_d;

    // ROB payload (no reset: qualified by entry state)
    logic [REG_ADDR_WIDTH-1:0] rd_q  [NUM_TAGS];
    logic [DATA_WIDTH-1:0]     res_q [NUM_TAGS];
    logic [4:0]                st_q  [NUM_TAGS];

    // Request register
    logic                      req_valid_q, req_valid_d;
    logic [3:0]                req_op_q;
    logic                      req_op_mod_q;
    logic [3*DATA_WIDTH-1:0]   req_operands_q;
    logic [TAG_WIDTH-1:0]      req_tag_q;

    // Status
    logic [4:0]                status_acc_q, status_acc_d;
    logic                      tag_err_q, tag_err_d;
    logic                      resp_ready_q;

    logic [TAG_WIDTH:0]        count;
    logic [TAG_WIDTH-1:0]      head_idx, tail_idx;
    logic                      full, instr_ready, accept;
    logic                      resp_fire, resp_hit, resp_bad;
    logic                      wb_valid, retire;

    assign head_idx    = head_q[TAG_WIDTH-1:0];
    assign tail_idx    = tail_q[TAG_WIDTH-1:0];
    // Extra wrap bit makes the modular difference the exact occupancy.
    assign count       = tail_q - head_q;
    assign full        = (count == PTR_FULL);
    assign instr_ready = !full && (!req_valid_q || bus.fpu_req_ready_i);
    assign accept      = bus.instr_valid_i && instr_ready;

    assign resp_fire   = bus.fpu_resp_valid_i && resp_ready_q;
    assign resp_hit    = resp_fire && (state_q[bus.fpu_resp_tag_i] == E_ISSUED);
    assign resp_bad    = resp_fire && (state_q[bus.fpu_resp_tag_i] != E_ISSUED);

    assign wb_valid    = (state_q[head_idx] == E_DONE);
    assign retire      = wb_valid && bus.wb_ready_i;

    // Retire frees head, response completes an ISSUED entry, accept claims a
    // FREE tail entry; the three can never target the same index in one cycle.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        status_acc_d = status_acc_q;
        tag_err_d    = tag_err_q;

        if (retire) begin
            state_d[head_idx] = E_FREE;
            head_d            = head_q + PTR_ONE;
        end
        if (resp_hit) begin
            state_d[bus.fpu_resp_tag_i] = E_DONE;
        end
        if (accept) begin
            state_d[tail_idx] = E_ISSUED;
            tail_d            = tail_q + PTR_ONE;
        end

        if (accept) begin
            req_valid_d = 1'b1;
        end else if (bus.fpu_req_ready_i) begin
            req_valid_d = 1'b0;
        end

        // Clear takes effect before the retiring flags are merged in.
        if (retire) begin
            status_acc_d = (bus.clr_status_i ? 5'd0 : status_acc_q) | st_q[head_idx];
        end else if (bus.clr_status_i) begin
            status_acc_d = 5'd0;
        end

        if (resp_bad) begin
            tag_err_d = 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                state_q[i] <= E_FREE;
            end
            req_valid_q  <= 1'b0;
            status_acc_q <= 5'd0;
            tag_err_q    <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            status_acc_q <= status_acc_d;
            tag_err_q    <= tag_err_d;
            resp_ready_q <= 1'b1;
        end
    end

    // Payload registers
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_q[tail_idx] <= bus.instr_rd_i;
            req_op_q       <= bus.instr_op_i;
            req_op_mod_q   <= bus.instr_op_mod_i;
            req_operands_q <= bus.instr_operands_i;
            req_tag_q      <= tail_idx;
        end
        if (resp_hit) begin
            res_q[bus.fpu_resp_tag_i] <= bus.fpu_resp_result_i;
            st_q[bus.fpu_resp_tag_i]  <= bus.fpu_resp_status_i;
        end
    end

    assign bus.instr_ready_o      = instr_ready;
    assign bus.fpu_req_valid_o    = req_valid_q;
    assign bus.fpu_req_op_o       = req_op_q;
    assign bus.fpu_req_op_mod_o   = req_op_mod_q;
    assign bus.fpu_req_operands_o = req_operands_q;
    assign bus.fpu_req_tag_o      = req_tag_q;
    assign bus.fpu_resp_ready_o   = resp_ready_q;
    assign bus.wb_valid_o         = wb_valid;
    assign bus.wb_rd_o            = rd_q[head_idx];
    assign bus.wb_data_o          = res_q[head_idx];
    assign bus.status_acc_o       = status_acc_q;
    assign bus.outstanding_o      = count;
    assign bus.tag_err_o          = tag_err_q;

endmodule
